// File: rtl/pe_pkg.sv
// Shared Tiny PE definitions: data widths, opcode map, instruction field
// positions, sequencer state encoding and small decode helpers.
package pe_pkg;

    localparam int DATA_W  = 16;
    localparam int REG_NUM = 8;
    localparam int REG_AW  = $clog2(REG_NUM);
    localparam int INS_W   = 16;

    // Instruction word layout: op | rd | rs1 | rs2 | reserved
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int RS1_MSB  = 8;
    localparam int RS1_LSB  = 6;
    localparam int RS2_MSB  = 5;
    localparam int RS2_LSB  = 3;
    localparam int RSVD_MSB = 2;

    typedef logic [OP_MSB-OP_LSB:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_ADD  = 4'h1;
    localparam opcode_t OP_SUB  = 4'h2;
    localparam opcode_t OP_MUL  = 4'h3;
    localparam opcode_t OP_AND  = 4'h4;
    localparam opcode_t OP_OR   = 4'h5;
    localparam opcode_t OP_NOT  = 4'h6;
    localparam opcode_t OP_XOR  = 4'h7;
    localparam opcode_t OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WB,
        S_DONE
    } state_t;

    function automatic opcode_t ins_op(input logic [INS_W-1:0] ins);
        return ins[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] ins_rd(input logic [INS_W-1:0] ins);
        return ins[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] ins_rs1(input logic [INS_W-1:0] ins);
        return ins[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] ins_rs2(input logic [INS_W-1:0] ins);
        return ins[RS2_MSB:RS2_LSB];
    endfunction

    function automatic logic is_alu_op(input opcode_t op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_MUL,
            OP_AND, OP_OR, OP_NOT, OP_XOR: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pe_sequencer_if.sv
// Sequencer-to-ALU link: operation strobe and operands out, registered result back.
interface pe_sequencer_if;
    import pe_pkg::*;

    logic              alu_en_out;
    logic [7:0]        alu_ins_out;
    logic [DATA_W-1:0] alu_a_out;
    logic [DATA_W-1:0] alu_b_out;
    logic [DATA_W-1:0] alu_c_in;
    logic              alu_valid_in;

    modport master (
        output alu_en_out, alu_ins_out, alu_a_out, alu_b_out,
        input  alu_c_in, alu_valid_in
    );

    modport slave (
        input  alu_en_out, alu_ins_out, alu_a_out, alu_b_out,
        output alu_c_in, alu_valid_in
    );

endinterface

// File: rtl/pe_regfile.sv
// 8x16 register file: one write port shared between host and sequencer
// (selected by host_sel_i), three asynchronous read ports.
module pe_regfile
    import pe_pkg::*;
(
    input  logic              CLK,
    input  logic              host_sel_i,
    input  logic              seq_we_i,
    input  logic [REG_AW-1:0] seq_addr_i,
    input  logic [DATA_W-1:0] seq_data_i,
    input  logic              host_we_i,
    input  logic [REG_AW-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic [REG_AW-1:0] host_rd_addr_i,
    output logic [DATA_W-1:0] host_rd_data_o
);

    logic [DATA_W-1:0] rf_q [REG_NUM];
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always_comb begin
        if (host_sel_i) begin
            wr_en   = host_we_i;
            wr_addr = host_addr_i;
            wr_data = host_data_i;
        end else begin
            wr_en   = seq_we_i;
            wr_addr = seq_addr_i;
            wr_data = seq_data_i;
        end
    end

    // NOTE: storage arrays get no reset so they map onto plain RAM/flop
    // arrays without a reset tree; contents survive RST.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

    assign rs1_data_o     = rf_q[rs1_addr_i];
    assign rs2_data_o     = rf_q[rs2_addr_i];
    assign host_rd_data_o = rf_q[host_rd_addr_i];

endmodule

// File: rtl/pe_sequencer.sv
// Tiny PE instruction sequencer: fetches from PMEM, drives the ALU, writes back.
// Optional busy-cycle counter output enabled by `define PE_SEQ_CYCLE_CNT_EN.
module pe_sequencer
    import pe_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = $clog2(PROG_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    input  logic              prog_we_in,
    input  logic [PC_W-1:0]   prog_addr_in,
    input  logic [INS_W-1:0]  prog_data_in,
    input  logic              reg_we_in,
    input  logic [REG_AW-1:0] reg_addr_in,
    input  logic [DATA_W-1:0] reg_data_in,
    input  logic [REG_AW-1:0] reg_rd_addr_in,
    output logic [DATA_W-1:0] reg_rd_data_out,
    pe_sequencer_if.master    alu
`ifdef PE_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]       cycle_cnt_out
`endif
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INS_W-1:0]  ir_q, ir_d;
    logic              err_q, err_d;
    logic [INS_W-1:0]  pmem_q [PROG_DEPTH];
    logic [INS_W-1:0]  fetch_word;
    opcode_t           fetch_op;
    opcode_t           ir_op;
    logic [REG_AW-1:0] ir_rd, ir_rs1, ir_rs2;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              seq_we;
    logic              is_idle;
    logic              is_issue;
    logic              unused_rsvd;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (is_idle && prog_we_in) begin
            pmem_q[prog_addr_in] <= prog_data_in;
        end
    end

    assign fetch_word  = pmem_q[pc_q];
    assign fetch_op    = ins_op(fetch_word);
    assign ir_op       = ins_op(ir_q);
    assign ir_rd       = ins_rd(ir_q);
    assign ir_rs1      = ins_rs1(ir_q);
    assign ir_rs2      = ins_rs2(ir_q);
    assign unused_rsvd = ^ir_q[RSVD_MSB:0];

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
        seq_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d = fetch_word;
                if (fetch_op == OP_HALT) begin
                    state_d = S_DONE;
                end else if (!is_alu_op(fetch_op)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WB;
            end
            S_WB: begin
                if (!alu.alu_valid_in) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    seq_we = 1'b1;
                    if (pc_q == PC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign is_idle  = (state_q == S_IDLE);
    assign is_issue = (state_q == S_ISSUE);
    assign busy_out = !is_idle;
    assign done_out = (state_q == S_DONE);
    assign err_out  = err_q;

    assign alu.alu_en_out  = is_issue;
    assign alu.alu_ins_out = is_issue ? {4'b0000, ir_op} : 8'h00;
    assign alu.alu_a_out   = is_issue ? rs1_data : '0;
    assign alu.alu_b_out   = is_issue ? rs2_data : '0;

    // Host writes land only while idle; otherwise the port belongs to WB.
    pe_regfile u_regfile (
        .CLK            (CLK),
        .host_sel_i     (is_idle),
        .seq_we_i       (seq_we),
        .seq_addr_i     (ir_rd),
        .seq_data_i     (alu.alu_c_in),
        .host_we_i      (reg_we_in),
        .host_addr_i    (reg_addr_in),
        .host_data_i    (reg_data_in),
        .rs1_addr_i     (ir_rs1),
        .rs1_data_o     (rs1_data),
        .rs2_addr_i     (ir_rs2),
        .rs2_data_o     (rs2_data),
        .host_rd_addr_i (reg_rd_addr_in),
        .host_rd_data_o (reg_rd_data_out)
    );

`ifdef PE_SEQ_CYCLE_CNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (is_idle && start_in) begin
            cyc_d = 16'h0000;
        end else if (busy_out && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cyc_q <= 16'h0000;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_cnt_out = cyc_q;
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: behavioural Q8.7 ALU, program model
// and an ALU-issue scoreboard, plus register-file and timing checks.
module tb_pe_sequencer;

    localparam logic [3:0] T_NOP  = 4'h0;
    localparam logic [3:0] T_ADD  = 4'h1;
    localparam logic [3:0] T_SUB  = 4'h2;
    localparam logic [3:0] T_MUL  = 4'h3;
    localparam logic [3:0] T_OR   = 4'h5;
    localparam logic [3:0] T_HALT = 4'hF;

    typedef struct packed {
        logic [7:0]  ins;
        logic [15:0] a;
        logic [15:0] b;
    } issue_t;

    logic        CLK;
    logic        RST;
    logic        start_in;
    logic        busy_out, done_out, err_out;
    logic        prog_we_in;
    logic [3:0]  prog_addr_in;
    logic [15:0] prog_data_in;
    logic        reg_we_in;
    logic [2:0]  reg_addr_in;
    logic [15:0] reg_data_in;
    logic [2:0]  reg_rd_addr_in;
    logic [15:0] reg_rd_data_out;
    logic [15:0] cycle_cnt;

    pe_sequencer_if alu_if ();

    pe_sequencer #(.PROG_DEPTH(16)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .start_in        (start_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .err_out         (err_out),
        .prog_we_in      (prog_we_in),
        .prog_addr_in    (prog_addr_in),
        .prog_data_in    (prog_data_in),
        .reg_we_in       (reg_we_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_rd_addr_in  (reg_rd_addr_in),
        .reg_rd_data_out (reg_rd_data_out),
        .alu             (alu_if)
`ifdef PE_SEQ_CYCLE_CNT_EN
        ,
        .cycle_cnt_out   (cycle_cnt)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          en_count = 0;
    bit          prev_en = 0;
    bit          drop_valid = 0;
    logic [15:0] model_rf   [8];
    logic [15:0] exp_rf     [8];
    logic [15:0] model_pmem [16];
    issue_t      exp_q [$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        case (op)
            4'h0: return a;
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: begin
                p = $signed(a) * $signed(b);
                return p[22:7];
            end
            4'h4: return a & b;
            4'h5: return a | b;
            4'h6: return ~a;
            4'h7: return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    // Behavioural ALU: result registered at the end of the enable cycle.
    always @(posedge CLK) begin
        alu_if.alu_valid_in <= alu_if.alu_en_out && !drop_valid;
        alu_if.alu_c_in     <= alu_if.alu_en_out ?
                               alu_fn(alu_if.alu_ins_out[3:0], alu_if.alu_a_out, alu_if.alu_b_out) : 16'h0000;
    end

    // Scoreboard: each ALU issue is popped and compared against the model.
    always @(negedge CLK) begin
        issue_t exp_it;
        if (alu_if.alu_en_out) begin
            en_count++;
            n_tests++;
            if (prev_en) begin
                n_fail++;
                $display("FAIL en_pulse: alu_en_out high on two consecutive cycles");
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got ins=%h a=%h b=%h, none expected",
                         alu_if.alu_ins_out, alu_if.alu_a_out, alu_if.alu_b_out);
            end else begin
                exp_it = exp_q.pop_front();
                if ({alu_if.alu_ins_out, alu_if.alu_a_out, alu_if.alu_b_out} !== exp_it) begin
                    n_fail++;
                    $display("FAIL issue: got ins=%h a=%h b=%h, want ins=%h a=%h b=%h",
                             alu_if.alu_ins_out, alu_if.alu_a_out, alu_if.alu_b_out,
                             exp_it.ins, exp_it.a, exp_it.b);
                end
            end
        end
        prev_en = alu_if.alu_en_out;
    end

    task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
        @(negedge CLK);
        reg_we_in   = 1'b1;
        reg_addr_in = addr;
        reg_data_in = data;
        @(negedge CLK);
        reg_we_in   = 1'b0;
        model_rf[addr] = data;
    endtask

    task automatic write_prog(input logic [3:0] addr, input logic [15:0] word);
        @(negedge CLK);
        prog_we_in   = 1'b1;
        prog_addr_in = addr;
        prog_data_in = word;
        @(negedge CLK);
        prog_we_in   = 1'b0;
        model_pmem[addr] = word;
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [15:0] data);
        @(negedge CLK);
        reg_rd_addr_in = addr;
        #1;
        data = reg_rd_data_out;
    endtask

    // Executes the loaded program on the model, queueing expected ALU issues.
    task automatic model_program(input bit drop_v, output int n_alu, output bit fetch_term, output bit exp_err);
        logic [15:0] w, a, b;
        logic [3:0]  op;
        int          pc;
        bit          stop;
        exp_rf = model_rf;
        n_alu = 0; fetch_term = 0; exp_err = 0; pc = 0; stop = 0;
        while (!stop) begin
            w  = model_pmem[pc];
            op = w[15:12];
            if (op == T_HALT) begin
                fetch_term = 1; stop = 1;
            end else if (op[3]) begin
                fetch_term = 1; exp_err = 1; stop = 1;
            end else begin
                a = exp_rf[w[8:6]];
                b = exp_rf[w[5:3]];
                exp_q.push_back('{ins: {4'h0, op}, a: a, b: b});
                n_alu++;
                if (drop_v) begin
                    exp_err = 1; stop = 1;
                end else begin
                    exp_rf[w[11:9]] = alu_fn(op, a, b);
                    if (pc == 15) stop = 1;
                    else pc++;
                end
            end
        end
    endtask

    task automatic run_program(input string tag, input bit drop_v, input bit disturb, output int lat);
        int          n_alu, exp_lat, cyc;
        bit          fterm, eerr, seen;
        logic [15:0] v;
        model_program(drop_v, n_alu, fterm, eerr);
        exp_lat    = 1 + 3 * n_alu + (fterm ? 1 : 0);
        drop_valid = drop_v;
        en_count   = 0;
        @(negedge CLK);
        start_in = 1'b1;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                start_in = 1'b0;
                n_tests++;
                if ({busy_out, err_out} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL %s start: busy/err=%b, want 10", tag, {busy_out, err_out});
                end
            end
            if (disturb && cyc == 5) begin
                start_in = 1'b1;
                reg_we_in = 1'b1; reg_addr_in = 3'd0; reg_data_in = 16'hDEAD;
                prog_we_in = 1'b1; prog_addr_in = 4'd0; prog_data_in = enc(T_HALT, 0, 0, 0);
            end
            if (disturb && cyc == 6) begin
                start_in = 1'b0; reg_we_in = 1'b0; prog_we_in = 1'b0;
            end
            if (done_out) seen = 1;
        end
        lat = cyc;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no done_out within %0d cycles", tag, cyc);
        end else if (cyc != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, want %0d", tag, cyc, exp_lat);
        end
        @(negedge CLK);
        drop_valid = 0;
        n_tests++;
        if ({done_out, busy_out, err_out} !== {2'b00, eerr}) begin
            n_fail++;
            $display("FAIL %s after_done: done/busy/err=%b, want 00%b", tag, {done_out, busy_out, err_out}, eerr);
        end
        n_tests++;
        if (en_count != n_alu || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s issues: got %0d enables (%0d left), want %0d", tag, en_count, exp_q.size(), n_alu);
            exp_q.delete();
        end
`ifdef PE_SEQ_CYCLE_CNT_EN
        n_tests++;
        if (cycle_cnt !== 16'(exp_lat)) begin
            n_fail++;
            $display("FAIL %s cycle_cnt: got %0d, want %0d", tag, cycle_cnt, exp_lat);
        end
`endif
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), v);
            n_tests++;
            if (v !== exp_rf[r]) begin
                n_fail++;
                $display("FAIL %s rf[%0d]: got %h, want %h", tag, r, v, exp_rf[r]);
            end
        end
        model_rf = exp_rf;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        RST = 1'b0;
        start_in = 0; prog_we_in = 0; prog_addr_in = 0; prog_data_in = 0;
        reg_we_in = 0; reg_addr_in = 0; reg_data_in = 0; reg_rd_addr_in = 0;
        repeat (3) @(negedge CLK);
        n_tests++;
        if ({busy_out, done_out, err_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got %b, want 000", {busy_out, done_out, err_out});
        end
        n_tests++;
        if ({alu_if.alu_en_out, alu_if.alu_ins_out, alu_if.alu_a_out, alu_if.alu_b_out} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_alu: got en=%b ins=%h a=%h b=%h, want all 0", alu_if.alu_en_out,
                     alu_if.alu_ins_out, alu_if.alu_a_out, alu_if.alu_b_out);
        end
        RST = 1'b1;
        write_reg(3'd0, 16'h0000);
        write_reg(3'd1, 16'h0100);
        write_reg(3'd2, 16'h0180);
        write_reg(3'd3, 16'h1111);
        write_reg(3'd4, 16'h2222);
        write_reg(3'd5, 16'h3333);
        write_reg(3'd6, 16'h4444);
        write_reg(3'd7, 16'h5555);
        read_reg(3'd2, v);
        n_tests++;
        if (v !== 16'h0180) begin
            n_fail++;
            $display("FAIL host_write: rf[2] got %h, want 0180", v);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [15:0] v;
        write_prog(4'd0, enc(T_ADD, 3, 1, 2));
        write_prog(4'd1, enc(T_HALT, 0, 0, 0));
        run_program("add", 0, 0, lat);
        read_reg(3'd3, v);
        n_tests++;
        if (v !== 16'h0280 || lat != 5) begin
            n_fail++;
            $display("FAIL add_const: rf[3]=%h lat=%0d, want 0280 lat=5", v, lat);
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [15:0] v;
        write_prog(4'd0, enc(T_MUL, 4, 1, 2));
        run_program("mul", 0, 0, lat);
        read_reg(3'd4, v);
        n_tests++;
        if (v !== 16'h0300) begin
            n_fail++;
            $display("FAIL mul_const: rf[4] got %h, want 0300", v);
        end
    endtask

    task automatic test_chain();
        int lat;
        logic [15:0] v;
        write_prog(4'd0, enc(T_ADD, 3, 1, 2));
        write_prog(4'd1, enc(T_SUB, 5, 3, 1));
        write_prog(4'd2, enc(T_HALT, 0, 0, 0));
        run_program("chain", 0, 0, lat);
        read_reg(3'd5, v);
        n_tests++;
        if (v !== 16'h0180 || lat != 8) begin
            n_fail++;
            $display("FAIL chain_const: rf[5]=%h lat=%0d, want 0180 lat=8", v, lat);
        end
    endtask

    task automatic test_illegal();
        int lat;
        write_prog(4'd0, 16'h9000);
        run_program("illegal", 0, 0, lat);
        n_tests++;
        if (err_out !== 1'b1 || lat != 2) begin
            n_fail++;
            $display("FAIL illegal_const: err=%b lat=%0d, want err=1 lat=2", err_out, lat);
        end
        write_prog(4'd0, enc(T_ADD, 3, 1, 2));
        write_prog(4'd1, enc(T_HALT, 0, 0, 0));
        run_program("err_clear", 0, 0, lat);
    endtask

    task automatic test_no_halt();
        int lat;
        for (int i = 0; i < 16; i++) write_prog(4'(i), enc(T_NOP, 0, 0, 0));
        run_program("no_halt", 0, 1, lat);
        n_tests++;
        if (lat != 49) begin
            n_fail++;
            $display("FAIL no_halt_const: lat got %0d, want 49", lat);
        end
    endtask

    task automatic test_valid_drop();
        int lat;
        logic [15:0] v;
        write_prog(4'd0, enc(T_ADD, 6, 1, 2));
        write_prog(4'd1, enc(T_HALT, 0, 0, 0));
        run_program("valid_drop", 1, 0, lat);
        read_reg(3'd6, v);
        n_tests++;
        if (v !== 16'h4444 || lat != 4) begin
            n_fail++;
            $display("FAIL valid_drop_const: rf[6]=%h lat=%0d, want 4444 lat=4", v, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int          n_alu, waited, lat;
        bit          ft, ee;
        logic [15:0] v;
        write_prog(4'd0, enc(T_OR, 7, 1, 2));
        write_prog(4'd1, enc(T_HALT, 0, 0, 0));
        model_program(0, n_alu, ft, ee);
        @(negedge CLK);
        start_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        waited = 0;
        while (!alu_if.alu_en_out && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        n_tests++;
        if (!alu_if.alu_en_out) begin
            n_fail++;
            $display("FAIL mid_reset_issue: no ISSUE seen within %0d cycles", waited);
        end
        #2 RST = 1'b0;
        #1;
        n_tests++;
        if ({busy_out, done_out, err_out, alu_if.alu_en_out, alu_if.alu_ins_out,
             alu_if.alu_a_out, alu_if.alu_b_out} !== 44'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b err=%b en=%b ins=%h a=%h b=%h, want all 0",
                     busy_out, done_out, err_out, alu_if.alu_en_out, alu_if.alu_ins_out,
                     alu_if.alu_a_out, alu_if.alu_b_out);
        end
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        read_reg(3'd7, v);
        n_tests++;
        if (v !== 16'h5555) begin
            n_fail++;
            $display("FAIL mid_reset_rf: rf[7] got %h, want 5555", v);
        end
        run_program("restart", 0, 0, lat);
        read_reg(3'd7, v);
        n_tests++;
        if (v !== 16'h0180) begin
            n_fail++;
            $display("FAIL restart_const: rf[7] got %h, want 0180", v);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_chain();
        test_illegal();
        test_no_halt();
        test_valid_drop();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
